// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares the single-port data memory between NUM_REQ requesters.
// Read results return tagged to the issuing requester after READ_LATENCY cycles.

module dmem_arbiter_rdStage #(
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           inVld,
    input  logic [IDW-1:0] inId,
    output logic           outVld,
    output logic [IDW-1:0] outId
);
    always_ff @(posedge clk) begin
        if (!rstN) begin
            outVld <= 1'b0;
            outId  <= '0;
        end else begin
            outVld <= inVld;
            outId  <= inId;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 36,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            wrEn,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wrData,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rdValid,
    output logic [DATA_WIDTH-1:0]         rdData,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wrEn,
    output logic [DATA_WIDTH-1:0]         mem_data,
    input  logic [DATA_WIDTH-1:0]         mem_q
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]        ptr, winner, nextPtr;
    logic                  anyReq, grant;
    logic [ADDR_WIDTH-1:0] addrArr [NUM_REQ];
    logic [DATA_WIDTH-1:0] dataArr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addrArr[gi] = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign dataArr[gi] = wrData[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        int j;
        winner = '0;
        anyReq = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j[IDW-1:0]]) begin
                winner = j[IDW-1:0];
                anyReq = 1'b1;
            end
        end
    end

    assign grant    = anyReq & rstN;
    assign gnt      = grant ? (NUM_REQ'(1) << winner) : '0;
    assign mem_addr = grant ? addrArr[winner] : '0;
    assign mem_data = grant ? dataArr[winner] : '0;
    assign mem_wrEn = grant & wrEn[winner];

    assign nextPtr = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstN)
            ptr <= '0;
        else if (grant)
            ptr <= lock[winner] ? winner : nextPtr;
    end

    logic [READ_LATENCY:0] vldPipe;
    logic [IDW-1:0]        idPipe [READ_LATENCY+1];

    assign vldPipe[0] = grant & ~mem_wrEn;
    assign idPipe[0]  = winner;

    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_rdPipe
            dmem_arbiter_rdStage #(.IDW(IDW)) uStage (
                .clk    (clk),
                .rstN   (rstN),
                .inVld  (vldPipe[gi]),
                .inId   (idPipe[gi]),
                .outVld (vldPipe[gi+1]),
                .outId  (idPipe[gi+1])
            );
        end
    endgenerate

    // Gated by rstN so a read landing in the reset cycle is also dropped.
    assign rdValid = (rstN && vldPipe[READ_LATENCY]) ? (NUM_REQ'(1) << idPipe[READ_LATENCY]) : '0;
    assign rdData  = mem_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan sequences plus randomized traffic
// checked against a queue-based reference model and a latency-accurate memory.

module tb_dmem_arbiter;
    localparam int N  = 3;
    localparam int DW = 36;
    localparam int AW = 12;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            rstN;
    logic [N-1:0]    req, wrEn, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wrData;
    logic [N-1:0]    gnt, rdValid;
    logic [DW-1:0]   rdData, mem_data, mem_q;
    logic [AW-1:0]   mem_addr;
    logic            mem_wrEn;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .req      (req),
        .wrEn     (wrEn),
        .lock     (lock),
        .addr     (addr),
        .wrData   (wrData),
        .gnt      (gnt),
        .rdValid  (rdValid),
        .rdData   (rdData),
        .mem_addr (mem_addr),
        .mem_wrEn (mem_wrEn),
        .mem_data (mem_data),
        .mem_q    (mem_q)
    );

    // Memory environment: registered read, RL cycles from address edge to mem_q.
    logic [DW-1:0] memArr [4096];
    logic [DW-1:0] qPipe [RL];
    always @(posedge clk) begin
        if (mem_wrEn) memArr[mem_addr] <= mem_data;
        qPipe[0] <= memArr[mem_addr];
        for (int i = 1; i < RL; i++) qPipe[i] <= qPipe[i-1];
    end
    assign mem_q = qPipe[RL-1];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] refMem [4096];
    rd_t           rdQ [$];
    int            ptr = 0;
    int            cyc = 0;
    int            nChecks = 0;
    int            nErrors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic setIdle();
        req = '0; wrEn = '0; lock = '0; addr = '0; wrData = '0;
    endtask

    task automatic setPort(input int i, input logic r, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r; wrEn[i] = w; lock[i] = l;
        addr[i*AW +: AW] = a;
        wrData[i*DW +: DW] = d;
    endtask

    // One cycle: check outputs against the model, then advance the model over the edge.
    task automatic tick();
        int            w;
        logic [N-1:0]  eGnt, eRv;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eData, eRd;
        logic          eWr;
        #1;
        w = -1;
        if (rstN) begin
            for (int k = 0; k < N; k++) begin
                int j = (ptr + k) % N;
                if (w < 0 && req[j]) w = j;
            end
        end
        eGnt = '0; eAddr = '0; eData = '0; eWr = 1'b0;
        if (w >= 0) begin
            eGnt  = N'(1 << w);
            eAddr = addr[w*AW +: AW];
            eData = wrData[w*DW +: DW];
            eWr   = wrEn[w];
        end
        eRv = '0; eRd = '0;
        if (rstN && rdQ.size() > 0 && rdQ[0].due == cyc) begin
            eRv = N'(1 << rdQ[0].id);
            eRd = rdQ[0].data;
        end
        chk("gnt", 64'(gnt), 64'(eGnt));
        chk("mem_addr", 64'(mem_addr), 64'(eAddr));
        chk("mem_data", 64'(mem_data), 64'(eData));
        chk("mem_wrEn", 64'(mem_wrEn), 64'(eWr));
        chk("rdValid", 64'(rdValid), 64'(eRv));
        if (eRv != '0) chk("rdData", 64'(rdData), 64'(eRd));
        @(posedge clk);
        if (rdQ.size() > 0 && rdQ[0].due <= cyc) void'(rdQ.pop_front());
        if (!rstN) begin
            ptr = 0;
            rdQ.delete();
        end else if (w >= 0) begin
            ptr = lock[w] ? w : (w + 1) % N;
            if (wrEn[w]) refMem[eAddr] = eData;
            else rdQ.push_back('{due: cyc + RL, id: w, data: refMem[eAddr]});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idleTicks(input int n);
        setIdle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic resetTicks(input int n);
        rstN = 1'b0;
        idleTicks(n);
        rstN = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            memArr[i] = DW'(i) * 36'h000010001 + 36'h5;
            refMem[i] = memArr[i];
        end
        memArr[5] = 36'h00000000A;
        refMem[5] = 36'h00000000A;
        rstN = 1'b0;
        setIdle();
        @(negedge clk);
        resetTicks(2);

        // Single read by requester 1
        setIdle(); setPort(1, 1, 0, 0, 12'h005, '0);
        tick();
        idleTicks(RL + 1);

        // Round-robin from reset, all requesters reading
        resetTicks(1);
        for (int i = 0; i < N; i++) setPort(i, 1, 0, 0, AW'(i + 16), '0);
        for (int i = 0; i < 6; i++) tick();
        idleTicks(RL + 1);

        // Lock burst by requester 0, then release
        resetTicks(1);
        setPort(0, 1, 0, 1, 12'h010, '0); setPort(1, 1, 0, 0, 12'h011, '0);
        for (int i = 0; i < 4; i++) tick();
        lock = '0;
        for (int i = 0; i < 3; i++) tick();
        idleTicks(RL + 1);

        // Write by requester 2, read-back by requester 0 on the next cycle
        setIdle(); setPort(2, 1, 1, 0, 12'h0FF, 36'h123456789);
        tick();
        setIdle(); setPort(0, 1, 0, 0, 12'h0FF, '0);
        tick();
        idleTicks(RL + 1);

        // Reset while a read is in flight
        setIdle(); setPort(0, 1, 0, 0, 12'h020, '0);
        tick();
        resetTicks(1);
        setIdle(); setPort(1, 1, 0, 0, 12'h021, '0); setPort(2, 1, 0, 0, 12'h022, '0);
        tick();
        idleTicks(RL + 1);

        // Idle stretch, then confirm ptr held
        idleTicks(10);
        for (int i = 0; i < N; i++) setPort(i, 1, 0, 0, AW'(i), '0);
        tick();
        idleTicks(RL + 1);

        // Randomized traffic over a small address window to exercise read-after-write
        for (int n = 0; n < 3000; n++) begin
            rstN = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < N; i++)
                setPort(i, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)),
                        {4'($urandom), 32'($urandom)});
            tick();
        end
        rstN = 1'b1;
        idleTicks(RL + 1);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port data memory (IP_dataMem, 36-bit words, 4096 deep) between up to NUM_REQ requesters: the UART data-memory interface, the multi-core processor, and a debug/readback port. It replaces the state-based address/data muxing in the FPGA top level with per-cycle grants. It also tracks read latency so each read result returns, tagged, to the requester that issued it. Locked bursts let one requester keep the memory for consecutive cycles.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 36, memory word width
- ADDR_WIDTH, 12, memory address width
- READ_LATENCY, 1, cycles from address-sampling edge to valid mem_q (1..3)

- clk  in  1  clock
- rstN  in  1  reset, synchronous, active-low
- req  in  NUM_REQ  access request per requester
- wrEn  in  NUM_REQ  1 = write, 0 = read (per requester)
- lock  in  NUM_REQ  keep priority after the current grant (burst)
- addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- wrData  in  NUM_REQ*DATA_WIDTH  flattened write data, sliced the same way
- gnt  out  NUM_REQ  one-hot grant, valid in the same cycle as req
- rdValid  out  NUM_REQ  one-hot; rdData is valid for that requester
- rdData  out  DATA_WIDTH  read data, broadcast to all requesters
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_wrEn  out  1  to memory write enable
- mem_data  out  DATA_WIDTH  to memory write data
- mem_q  in  DATA_WIDTH  from memory read data

## Operation
- Register `ptr` (index of highest-priority requester) resets to 0.
- Winner selection, combinational: the first i with req[i]=1, searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (wraps modulo NUM_REQ).
- gnt[winner]=1 and all other bits 0. gnt is all zero when no req is high or rstN=0.
- Memory drive, all combinational from the winner:
  - mem_addr = addr[winner]
  - mem_data = wrData[winner]
  - mem_wrEn = wrEn[winner] & |gnt
- With no grant: mem_addr = 0, mem_data = 0, mem_wrEn = 0.
- Pointer update on every clock edge with a grant:
  - ptr <= winner if lock[winner]=1;
  - otherwise ptr <= (winner+1) mod NUM_REQ.
- With no grant, ptr holds.
- lock from a non-winning requester has no effect.
- Read tracking: a shift pipe of READ_LATENCY stages, each stage {valid, id}.
  - Stage 0 loads {|gnt & ~mem_wrEn, winner} every edge.
  - The last stage drives rdValid[id] = valid; rdData = mem_q unconditionally.
- Writes produce no rdValid.
- A granted write followed by a read of the same address on the next cycle returns the new data; this relies on IP memory read-after-write across cycles.
- Requester rules:
  - hold req, wrEn, addr and wrData stable until gnt is seen;
  - the access is committed on the edge where gnt=1;
  - drop req or change the address on the following cycle.

## Timing
- Grant latency 0 cycles; the memory address is sampled at the grant edge.
- Read data latency is READ_LATENCY cycles after the grant edge.
- Reads issued back-to-back by different requesters return in issue order, one per cycle, with no stall.
- Throughput: 1 access per cycle.
- Fairness: with all NUM_REQ requesting and no lock, each requester is granted once every NUM_REQ cycles.
- Reset values:
  - gnt = 0, rdValid = 0, mem_wrEn = 0, ptr = 0;
  - all pipe valid bits = 0.
- Reset mid-operation: in-flight reads are discarded and no rdValid is issued for them. A write sampled in the reset cycle is not performed, because mem_wrEn is forced 0.
- Simultaneous events:
  - Lock held by the winner starves the others. This is intended and is bounded by the requester.
  - Lock deasserted with req still high: the winner gets one final grant, then ptr advances.
- ptr wraps from NUM_REQ-1 to 0.

## Test plan
- Single read: req[1]=1, wrEn=0, addr=12'h005, memory holds 36'h00000000A. Expect gnt=3'b010 the same cycle and mem_addr=12'h005. After 1 cycle, rdValid=3'b010 and rdData=36'h00000000A.
- Round-robin: req=3'b111, all reads, held 6 cycles from reset. Expect gnt sequence 001, 010, 100, 001, 010, 100, and rdValid following it 1 cycle later.
- Lock burst: req=3'b011, lock[0]=1 for 4 cycles, then lock[0]=0. Expect gnt=001 ×5 (4 locked grants plus the release grant), then 010.
- Write then read: requester 2 writes 36'h123456789 to 12'h0FF; next cycle requester 0 reads 12'h0FF. Expect mem_wrEn=1 only in the first cycle, and rdValid=3'b001 with rdData=36'h123456789.
- Reset mid-read (READ_LATENCY=2): issue a read, assert rstN=0 the next cycle. Expect rdValid to stay 0 throughout, and ptr=0 after release (req=3'b110 → gnt=010).
- Idle: req=0 for 10 cycles. Expect gnt=0, mem_wrEn=0, mem_addr=0, rdValid=0, and ptr unchanged.
